// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor request path: FSM states, error codes,
// default device map base and command codes.
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_PRESENT   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ADDR    = 2'd2;
    localparam logic [1:0] ERR_CMD     = 2'd3;

    // The DHT11 sits at device 0 of the map.
    localparam logic [7:0] DHT11_ADDR_BASE = 8'h20;

    localparam logic [7:0] CMD_NOP         = 8'h00;
    localparam logic [7:0] CMD_READ_TEMP   = 8'h01;
    localparam logic [7:0] CMD_READ_HUMID  = 8'h02;
    localparam logic [7:0] CMD_READ_BOTH   = 8'h03;
    localparam logic [7:0] CMD_STATUS      = 8'h04;
    localparam logic [7:0] CMD_RESET_DEV   = 8'h05;
    localparam logic [7:0] CMD_CALIBRATE   = 8'h06;
    localparam logic [7:0] CMD_IDENTIFY    = 8'h07;
    localparam logic [7:0] DEFAULT_MAX_CMD = 8'h07;

endpackage

// File: rtl/sensor_request_decoder_if.sv
// Bundle between the UART receiver, the request decoder and the sensor-side consumer.
// The master modport is the decoder; the slave modport is its surrounding environment.
interface sensor_request_decoder_if #(
    parameter int NUM_DEVICES = 32
);
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   req_valid;
    logic                   req_ack;
    logic [7:0]             request;
    logic [NUM_DEVICES-1:0] device_selector;
    logic                   device_selected;
    logic                   req_error;
    logic [1:0]             error_code;
    logic [7:0]             drop_count;
    logic [1:0]             debug_state;

    modport master (
        input  rx_valid, rx_data, req_ack,
        output req_valid, request, device_selector, device_selected,
               req_error, error_code, drop_count, debug_state
    );

    modport slave (
        output rx_valid, rx_data, req_ack,
        input  req_valid, request, device_selector, device_selected,
               req_error, error_code, drop_count, debug_state
    );
endinterface

// File: rtl/sensor_addr_decode.sv
// Combinational address decoder: maps an address byte onto a one-hot device selector.
// Range checks are done in 9 bits so the top of the map never wraps past 8'hFF.
module sensor_addr_decode #(
    parameter int         NUM_DEVICES = 32,
    parameter logic [7:0] ADDR_BASE   = 8'h20
) (
    input  logic [7:0]             addr,
    output logic [NUM_DEVICES-1:0] one_hot,
    output logic                   hit
);
    localparam logic [8:0] BASE_EXT = {1'b0, ADDR_BASE};
    localparam logic [8:0] LAST_EXT = BASE_EXT + 9'(NUM_DEVICES - 1);

    logic [8:0] addr_ext;
    logic [8:0] offset;

    assign addr_ext = {1'b0, addr};
    assign offset   = addr_ext - BASE_EXT;
    assign hit      = (addr_ext >= BASE_EXT) && (addr_ext <= LAST_EXT);

    always_comb begin
        one_hot = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            one_hot[i] = hit && (offset == 9'(i));
        end
    end
endmodule

// File: rtl/sensor_request_decoder.sv
// Assembles command+address byte pairs from the UART into a held, decoded request,
// reporting inter-byte timeouts, unmapped addresses and illegal commands as errors.
module sensor_request_decoder
    import sensor_pkg::*;
#(
    parameter int         NUM_DEVICES    = 32,
    parameter logic [7:0] ADDR_BASE      = DHT11_ADDR_BASE,
    parameter logic [7:0] MAX_CMD        = DEFAULT_MAX_CMD,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input logic                      clock,
    input logic                      reset,
    sensor_request_decoder_if.master bus
);
    localparam int               TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d, timer_inc;
    logic [7:0]             cmd_q, cmd_d;
    logic                   req_valid_q, req_valid_d;
    logic [7:0]             request_q, request_d;
    logic [NUM_DEVICES-1:0] selector_q, selector_d;
    logic                   req_error_q, req_error_d;
    logic [1:0]             error_code_q, error_code_d;
    logic [7:0]             drop_q, drop_d;

    logic [NUM_DEVICES-1:0] dec_one_hot;
    logic                   dec_hit;

    sensor_addr_decode #(
        .NUM_DEVICES (NUM_DEVICES),
        .ADDR_BASE   (ADDR_BASE)
    ) u_addr_decode (
        .addr    (bus.rx_data),
        .one_hot (dec_one_hot),
        .hit     (dec_hit)
    );

    assign timer_inc = timer_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            cmd_q        <= '0;
            req_valid_q  <= 1'b0;
            request_q    <= '0;
            selector_q   <= '0;
            req_error_q  <= 1'b0;
            error_code_q <= ERR_NONE;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cmd_q        <= cmd_d;
            req_valid_q  <= req_valid_d;
            request_q    <= request_d;
            selector_q   <= selector_d;
            req_error_q  <= req_error_d;
            error_code_q <= error_code_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cmd_d        = cmd_q;
        req_valid_d  = req_valid_q;
        request_d    = request_q;
        selector_d   = selector_q;
        req_error_d  = req_error_q;
        error_code_d = error_code_q;
        drop_d       = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    cmd_d   = bus.rx_data;
                    timer_d = '0;
                    state_d = ST_WAIT_ADDR;
                end
            end

            ST_WAIT_ADDR: begin
                // An address byte arriving on the timeout cycle still wins.
                if (bus.rx_valid) begin
                    state_d     = ST_PRESENT;
                    req_valid_d = 1'b1;
                    request_d   = cmd_q;
                    if (cmd_q > MAX_CMD) begin
                        selector_d   = '0;
                        req_error_d  = 1'b1;
                        error_code_d = ERR_CMD;
                    end else if (!dec_hit) begin
                        selector_d   = '0;
                        req_error_d  = 1'b1;
                        error_code_d = ERR_ADDR;
                    end else begin
                        selector_d   = dec_one_hot;
                        req_error_d  = 1'b0;
                        error_code_d = ERR_NONE;
                    end
                end else if (timer_inc == TIMER_LAST) begin
                    state_d      = ST_PRESENT;
                    req_valid_d  = 1'b1;
                    request_d    = cmd_q;
                    selector_d   = '0;
                    req_error_d  = 1'b1;
                    error_code_d = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_inc;
                end
            end

            ST_PRESENT: begin
                if (bus.rx_valid && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (bus.req_ack) begin
                    state_d      = ST_IDLE;
                    req_valid_d  = 1'b0;
                    selector_d   = '0;
                    req_error_d  = 1'b0;
                    error_code_d = ERR_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_valid       = req_valid_q;
    assign bus.request         = request_q;
    assign bus.device_selector = selector_q;
    assign bus.device_selected = |selector_q;
    assign bus.req_error       = req_error_q;
    assign bus.error_code      = error_code_q;
    assign bus.drop_count      = drop_q;
    assign bus.debug_state     = state_q;
endmodule
